// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared branch-mode encodings and sequencer FSM states
// for the naiveCPU fetch-address unit.
package pc_seq_pkg;

    // Branch/jump modes driven by the decode stage
    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [2:0] MODE_BEQZ  = 3'b001;
    localparam logic [2:0] MODE_BNEZ  = 3'b010;
    localparam logic [2:0] MODE_BTEQZ = 3'b011;
    localparam logic [2:0] MODE_BTNEZ = 3'b100;
    localparam logic [2:0] MODE_JR    = 3'b101;
    localparam logic [2:0] MODE_B     = 3'b110;
    localparam logic [2:0] MODE_ERET  = 3'b111;

    // Sequencer states: TRAP doubles as the "handler active" flag
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOLD = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_t;

endpackage

// File: rtl/pc_branch_eval.sv
// pc_branch_eval: combinational branch resolution. Decides whether the
// decode-stage mode is taken and produces the jump target.
module pc_branch_eval
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] rs,
    input  logic              t,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] epc,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] rel_target;

    // Relative target wraps modulo 2^ADDR_W; no overflow is reported
    assign imm_ext    = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign rel_target = base + imm_ext;

    // Select taken/target per mode; not-taken leaves target unused
    always_comb begin
        taken  = 1'b0;
        target = rel_target;
        case (mode)
            MODE_BEQZ:  taken = (rs == '0);
            MODE_BNEZ:  taken = (rs != '0);
            MODE_BTEQZ: taken = (t == 1'b0);
            MODE_BTNEZ: taken = (t == 1'b1);
            MODE_JR: begin
                taken  = 1'b1;
                target = rs;
            end
            MODE_B:     taken = 1'b1;
            MODE_ERET: begin
                taken  = 1'b1;
                target = epc;
            end
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with stall hold, trap entry/return
// and a registered redirect pulse for wrong-path squash.
// Optional build macro: PC_ALIGN_CHECK_EN (odd taken targets trap and
// set the sticky misalign_o output).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              IMM_W     = 8,
    parameter int              INST_STEP = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0] TRAP_VEC = 16'h0008
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic [2:0]        mode_i,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic              t_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              trap_i,
`ifdef PC_ALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic [ADDR_W-1:0] pc_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              in_trap_o
);

    pc_state_t         state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic [ADDR_W-1:0] epc_q, epc_next;
    logic              redirect_q, redirect_next;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              in_trap;
    logic              align_trap;
    logic              trap_accept;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign_q, misalign_next;
`endif

    pc_branch_eval #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_branch_eval (
        .mode   (mode_i),
        .rs     (rs_i),
        .t      (t_i),
        .imm    (imm_i),
        .base   (base_i),
        .epc    (epc_q),
        .taken  (taken),
        .target (target)
    );

    assign in_trap = (state == ST_TRAP);

    // A misaligned target only counts when the branch is actually consumed
    // (not stalled) and no handler is already running.
`ifdef PC_ALIGN_CHECK_EN
    assign align_trap = taken && target[0] && !stall_i && !in_trap;
`else
    assign align_trap = 1'b0;
`endif

    // Nested traps and trap/ERET collisions drop out here: no accept in TRAP
    assign trap_accept = !in_trap && (trap_i || align_trap);

    // Next-state and next-PC selection in priority order: trap, stall, branch, step
    always_comb begin
        state_next    = state;
        pc_next       = pc_q + ADDR_W'(INST_STEP);
        epc_next      = epc_q;
        redirect_next = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misalign_next = misalign_q;
`endif
        if (trap_accept) begin
            pc_next       = TRAP_VEC;
            redirect_next = 1'b1;
            state_next    = ST_TRAP;
`ifdef PC_ALIGN_CHECK_EN
            epc_next      = trap_i ? pc_q : target;
            misalign_next = misalign_q | align_trap;
`else
            epc_next      = pc_q;
`endif
        end else if (stall_i) begin
            pc_next    = pc_q;
            state_next = in_trap ? ST_TRAP : ST_HOLD;
        end else if (taken) begin
            pc_next       = target;
            redirect_next = 1'b1;
            if (mode_i == MODE_ERET) begin
                state_next = ST_RUN;
`ifdef PC_ALIGN_CHECK_EN
                misalign_next = 1'b0;
`endif
            end else begin
                state_next = in_trap ? ST_TRAP : ST_RUN;
            end
        end else begin
            state_next = in_trap ? ST_TRAP : ST_RUN;
        end
    end

    // State and fetch registers; async reset discards any pending redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            epc_q      <= epc_next;
            redirect_q <= redirect_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared by the handler's ERET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_next;
    end

    assign misalign_o = misalign_q;
`endif

    assign pc_o       = pc_q;
    assign redirect_o = redirect_q;
    assign epc_o      = epc_q;
    assign in_trap_o  = in_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a scoreboard queue; a monitor
// process compares each post-edge output against the queued expectation.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  mode;
    logic [15:0] rs;
    logic        tflag;
    logic [7:0]  imm;
    logic [15:0] base;
    logic        trap;
    logic [15:0] pc;
    logic        redirect;
    logic [15:0] epc;
    logic        in_trap;
    logic        misalign;

    typedef struct {
        int          id;
        logic [15:0] pc;
        logic        red;
        logic [15:0] epc;
        logic        trap;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .mode_i     (mode),
        .rs_i       (rs),
        .t_i        (tflag),
        .imm_i      (imm),
        .base_i     (base),
        .trap_i     (trap),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o (misalign),
`endif
        .pc_o       (pc),
        .redirect_o (redirect),
        .epc_o      (epc),
        .in_trap_o  (in_trap)
    );

`ifndef PC_ALIGN_CHECK_EN
    assign misalign = 1'b0;
`endif

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every visible output against one expectation
    task automatic checkOutput(input exp_t e);
        checks++;
        if (pc !== e.pc) begin
            failures++;
            $display("[TB] FAIL step%0d pc actual=%h required=%h", e.id, pc, e.pc);
        end
        checks++;
        if (redirect !== e.red) begin
            failures++;
            $display("[TB] FAIL step%0d redirect actual=%b required=%b", e.id, redirect, e.red);
        end
        checks++;
        if (epc !== e.epc) begin
            failures++;
            $display("[TB] FAIL step%0d epc actual=%h required=%h", e.id, epc, e.epc);
        end
        checks++;
        if (in_trap !== e.trap) begin
            failures++;
            $display("[TB] FAIL step%0d in_trap actual=%b required=%b", e.id, in_trap, e.trap);
        end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misalign !== e.mis) begin
            failures++;
            $display("[TB] FAIL step%0d misalign actual=%b required=%b", e.id, misalign, e.mis);
        end
`endif
    endtask

    // Drive one cycle of inputs at a falling edge and queue the post-edge result
    task automatic applyStimulus(
        input logic s, input logic [2:0] m, input logic [15:0] r,
        input logic tf, input logic [7:0] im, input logic [15:0] b,
        input logic tr,
        input logic [15:0] e_pc, input logic e_red, input logic [15:0] e_epc,
        input logic e_trap, input logic e_mis);
        exp_t e;
        stall = s; mode = m; rs = r; tflag = tf; imm = im; base = b; trap = tr;
        step++;
        e.id = step; e.pc = e_pc; e.red = e_red; e.epc = e_epc;
        e.trap = e_trap; e.mis = e_mis;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: sample after each rising edge and pop one expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        exp_t r;
        rst = 1'b0; stall = 0; mode = MODE_NONE; rs = 0; tflag = 0;
        imm = 0; base = 0; trap = 0;
        r.id = 0; r.pc = 16'h0000; r.red = 0; r.epc = 16'h0000; r.trap = 0; r.mis = 0;
        #2;
        checkOutput(r);
        @(negedge clk);
        rst = 1'b1;

        // Sequential stepping from reset up to 0010
        for (int k = 2; k <= 16; k += 2)
            applyStimulus(0, MODE_NONE, 0, 0, 0, 0, 0, 16'(k), 0, 16'h0000, 0, 0);

        // Conditional branches: taken and not taken
        applyStimulus(0, MODE_BNEZ,  16'h0005, 0, 8'hFC, 16'h0012, 0, 16'h000E, 1, 16'h0000, 0, 0);
        applyStimulus(0, MODE_NONE,  0,        0, 0,     0,        0, 16'h0010, 0, 16'h0000, 0, 0);
        applyStimulus(0, MODE_BNEZ,  16'h0000, 0, 8'hFC, 16'h0012, 0, 16'h0012, 0, 16'h0000, 0, 0);
        applyStimulus(0, MODE_BEQZ,  16'h0000, 0, 8'h10, 16'h0100, 0, 16'h0110, 1, 16'h0000, 0, 0);
        applyStimulus(0, MODE_BTEQZ, 0,        1, 8'h10, 16'h0500, 0, 16'h0112, 0, 16'h0000, 0, 0);
        applyStimulus(0, MODE_BTNEZ, 0,        1, 8'h7E, 16'h0200, 0, 16'h027E, 1, 16'h0000, 0, 0);
        applyStimulus(0, MODE_BTEQZ, 0,        0, 8'h80, 16'h0300, 0, 16'h0280, 1, 16'h0000, 0, 0);

        // Wrap-around: sequential and relative
        applyStimulus(0, MODE_JR,   16'hFFFE, 0, 0,     0,        0, 16'hFFFE, 1, 16'h0000, 0, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0,     0,        0, 16'h0000, 0, 16'h0000, 0, 0);
        applyStimulus(0, MODE_B,    0,        0, 8'h20, 16'hFFF0, 0, 16'h0010, 1, 16'h0000, 0, 0);

        // Stall holds a pending JR until released
        for (int k = 0; k < 3; k++)
            applyStimulus(1, MODE_JR, 16'h1234, 0, 0, 0, 0, 16'h0010, 0, 16'h0000, 0, 0);
        applyStimulus(0, MODE_JR,   16'h1234, 0, 0, 0, 0, 16'h1234, 1, 16'h0000, 0, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0, 0, 0, 16'h1236, 0, 16'h0000, 0, 0);

        // Trap entry over stall+branch, nested trap ignored, stalled ERET held
        applyStimulus(0, MODE_JR,   16'h0040, 0, 0,     0,        0, 16'h0040, 1, 16'h0000, 0, 0);
        applyStimulus(1, MODE_B,    0,        0, 8'h10, 16'h0100, 1, 16'h0008, 1, 16'h0040, 1, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0,     0,        1, 16'h000A, 0, 16'h0040, 1, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0,     0,        0, 16'h000C, 0, 16'h0040, 1, 0);
        applyStimulus(1, MODE_ERET, 0,        0, 0,     0,        0, 16'h000C, 0, 16'h0040, 1, 0);
        // ERET/trap collision: ERET wins, trap accepted next cycle
        applyStimulus(0, MODE_ERET, 0,        0, 0,     0,        1, 16'h0040, 1, 16'h0040, 0, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0,     0,        1, 16'h0008, 1, 16'h0040, 1, 0);
        applyStimulus(0, MODE_ERET, 0,        0, 0,     0,        0, 16'h0040, 1, 16'h0040, 0, 0);
        // ERET outside a trap just jumps to epc
        applyStimulus(0, MODE_ERET, 0,        0, 0,     0,        0, 16'h0040, 1, 16'h0040, 0, 0);
        applyStimulus(0, MODE_NONE, 0,        0, 0,     0,        0, 16'h0042, 0, 16'h0040, 0, 0);

        // Odd jump targets
`ifdef PC_ALIGN_CHECK_EN
        applyStimulus(0, MODE_JR,   16'h0031, 0, 0, 0, 0, 16'h0008, 1, 16'h0031, 1, 1);
        applyStimulus(0, MODE_JR,   16'h0033, 0, 0, 0, 0, 16'h0033, 1, 16'h0031, 1, 1);
        applyStimulus(0, MODE_ERET, 0,        0, 0, 0, 0, 16'h0031, 1, 16'h0031, 0, 0);
`else
        applyStimulus(0, MODE_JR,   16'h0031, 0, 0, 0, 0, 16'h0031, 1, 16'h0040, 0, 0);
        applyStimulus(0, MODE_JR,   16'h0033, 0, 0, 0, 0, 16'h0033, 1, 16'h0040, 0, 0);
        applyStimulus(0, MODE_ERET, 0,        0, 0, 0, 0, 16'h0040, 1, 16'h0040, 0, 0);
`endif

        // Asynchronous reset while a redirect is showing
        #2;
        rst = 1'b0;
        #1;
        r.id = 999; r.pc = 16'h0000; r.red = 0; r.epc = 16'h0000; r.trap = 0; r.mis = 0;
        checkOutput(r);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, MODE_NONE, 0, 0, 0, 0, 0, 16'h0002, 0, 16'h0000, 0, 0);

        // Drain bound: every queued expectation must have been compared
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-PC unit and fetch-address register for the naiveCPU core. It replaces pure combinational next-PC generation with a registered fetch PC. It adds stall hold, a trap entry/return sequence with a saved exception PC, and a registered redirect pulse that the fetch stage uses to squash the wrong-path instruction. Branch modes are resolved from decode-stage operands.

Parameters:
ADDR_W, 16, PC/address width in bits
IMM_W, 8, width of the branch offset field; sign-extended to ADDR_W
INST_STEP, 2, sequential PC increment
RESET_PC, 16'h0000, first fetch address after reset (ADDR_W bits)
TRAP_VEC, 16'h0008, trap entry address (ADDR_W bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
stall_i  input  1  hold PC (pipeline stall)
mode_i  input  3  branch/jump mode from decode
rs_i  input  ADDR_W  register operand (condition and JR target)
t_i  input  1  T flag
imm_i  input  IMM_W  raw branch offset
base_i  input  ADDR_W  branch base address supplied by decode
trap_i  input  1  trap request (level, sampled each edge)
pc_o  output  ADDR_W  registered fetch address
redirect_o  output  1  registered pulse: pc_o holds a non-sequential value this cycle
epc_o  output  ADDR_W  saved return address
in_trap_o  output  1  trap handler active

Behaviour:
- Reset (rst=0, async):
  - pc_o=RESET_PC, redirect_o=0, epc_o=0, in_trap_o=0, FSM=RUN.
  - Reset mid-operation discards any pending redirect.
- Mode encoding:
  - 000 NONE.
  - 001 BEQZ: taken if rs_i==0.
  - 010 BNEZ: taken if rs_i!=0.
  - 011 BTEQZ: taken if t_i==0.
  - 100 BTNEZ: taken if t_i==1.
  - 101 JR: always taken, target rs_i.
  - 110 B: always taken.
  - 111 ERET: always taken, target epc_o.
- Branch target: base_i + sext(imm_i), computed modulo 2^ADDR_W (wrap-around, no overflow flag).
- Per-edge priority, highest first:
  1. Trap accept: trap_i=1 and in_trap_o=0. Result: pc_o<=TRAP_VEC, epc_o<=pc_o, in_trap_o<=1, redirect_o<=1. Trap overrides stall and branch.
  2. Stall: stall_i=1. Result: pc_o and epc_o hold, redirect_o<=0. A branch presented under stall is not consumed; decode holds mode_i.
  3. Taken branch/jump. Result: pc_o<=target, redirect_o<=1. ERET additionally clears in_trap_o.
  4. Otherwise: pc_o<=pc_o+INST_STEP (wraps), redirect_o<=0.
- Nested traps: trap_i while in_trap_o=1 is ignored (no state change).
- Trap/ERET collision: trap_i on the same edge as an ERET, while in_trap_o=1, is ignored; the ERET completes. A trap still asserted next cycle is accepted.
- Latency: one cycle from inputs to pc_o. Not-taken conditional branches behave exactly like NONE.
- FSM states:
  - RUN: normal sequencing.
  - HOLD: entered while stall_i=1; returns to RUN the cycle stall_i drops.
  - TRAP: in_trap_o=1; sequences like RUN; left only by ERET.
- State transitions: RUN/HOLD to TRAP on trap accept; TRAP to RUN on an ERET taken without stall.
- ERET outside TRAP: jumps to epc_o, in_trap_o stays 0.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A taken target with target[0]=1 (any mode) is treated as a trap request.
  - Trap entry follows the normal rules, with epc_o<=target.
  - The sticky output misalign_o (1 bit, reset 0) sets; ERET clears it.
  - If in_trap_o=1, the misaligned target is loaded unchanged.
- Undefined: no check; misalign_o is absent; odd targets are loaded as-is.

Decomposition:
- Package pc_seq_pkg:
  - mode localparams (MODE_NONE..MODE_ERET, 3 bits)
  - FSM state encoding (ST_RUN, ST_HOLD, ST_TRAP)
- Sub-module pc_branch_eval (combinational):
  - inputs: mode, rs, t, imm, base, epc
  - outputs: taken and target
  - sign extension and addition live here.

Test Plan:
- Reset release with all inputs 0 -> pc_o=0000, then 0002, 0004 on successive edges; redirect_o=0.
- pc_o=0010, mode=BNEZ, rs=0005, base=0012, imm=8'hFC -> next pc_o=000E, redirect_o=1 for one cycle. Repeat with rs=0 -> pc_o=0012, redirect_o=0.
- pc_o=FFFE with NONE -> wraps to 0000. Also B with base=FFF0, imm=8'h20 -> 0010.
- stall_i=1 for 3 cycles with mode=JR, rs=1234 -> pc_o frozen, redirect_o=0. First unstalled edge -> pc_o=1234, redirect_o=1.
- At pc_o=0040, trap_i=1 together with stall_i=1 and mode=B -> pc_o=0008, epc_o=0040, in_trap_o=1. Second trap_i while in TRAP is ignored. ERET -> pc_o=0040, in_trap_o=0.
- PC_ALIGN_CHECK_EN: JR rs=0031 -> pc_o=0008, epc_o=0031, misalign_o=1. Without the macro -> pc_o=0031.
